// File: rtl/sram_release_ctrl.sv
// rtl/sram_release_ctrl.sv - release-side controller returning owned SRAM IDs to the free pool
module sram_release_ctrl #(
  parameter int NUM_PORTS = 16,
  parameter int NUM_SRAM  = 32,
  parameter int ID_W      = 5,
  parameter int PORT_W    = 4,
  parameter int MIN_HOLD  = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alloc_valid,
  input  logic [PORT_W-1:0]    alloc_port,
  input  logic [ID_W-1:0]      alloc_sram_id,
  input  logic [NUM_PORTS-1:0] rel_req,
  input  logic                 free_ready,
  output logic                 free_valid,
  output logic [ID_W-1:0]      free_sram_id,
  output logic [NUM_PORTS-1:0] rel_done,
  output logic [NUM_PORTS-1:0] short_err,
  output logic                 alloc_err,
  output logic [NUM_SRAM-1:0]  owned_vec,
  output logic                 busy
);

  localparam int CNT_W = $clog2(MIN_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MIN_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MIN_HOLD - 1);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_SRAM - 1);

  typedef enum logic [1:0] {IDLE, SCAN, ISSUE, DONE} state_t;

  state_t               state;
  logic [PORT_W-1:0]    owner [NUM_SRAM];
  logic [NUM_SRAM-1:0]  own_v;
  logic [CNT_W-1:0]     hold_cnt [NUM_PORTS];
  logic [NUM_PORTS-1:0] armed;
  logic [NUM_PORTS-1:0] pending;
  logic [PORT_W-1:0]    last_grant;
  logic [PORT_W-1:0]    gport;
  logic [ID_W-1:0]      ptr;

  logic                 handshake;
  logic                 grant_found;
  logic [PORT_W-1:0]    grant_sel;
  logic [PORT_W-1:0]    rr_idx;
  logic                 cand_found;
  logic [ID_W-1:0]      cand_sel;

  // free_valid is only ever high in ISSUE, so this is the pool handshake
  assign handshake = (state == ISSUE) && free_ready;
  assign owned_vec = own_v;
  assign busy      = (state != IDLE);

  // Round-robin pick: first pending port strictly after the last grant, wrapping
  always_comb begin
    grant_found = 1'b0;
    grant_sel   = '0;
    rr_idx      = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      rr_idx = PORT_W'((int'(last_grant) + i) % NUM_PORTS);
      if (!grant_found && pending[rr_idx]) begin
        grant_found = 1'b1;
        grant_sel   = rr_idx;
      end
    end
  end

  // Lowest owned SRAM of the granted port at or above the scan pointer
  always_comb begin
    cand_found = 1'b0;
    cand_sel   = '0;
    for (int i = NUM_SRAM - 1; i >= 0; i--) begin
      if (own_v[i] && (owner[i] == gport) && (ID_W'(i) >= ptr)) begin
        cand_found = 1'b1;
        cand_sel   = ID_W'(i);
      end
    end
  end

  // Ownership table: release clear lands first so a same-cycle alloc re-owns the SRAM cleanly
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      own_v     <= '0;
      alloc_err <= 1'b0;
      for (int i = 0; i < NUM_SRAM; i++) owner[i] <= '0;
    end else begin
      alloc_err <= 1'b0;
      if (handshake) own_v[free_sram_id] <= 1'b0;
      if (alloc_valid) begin
        if ({1'b0, alloc_sram_id} >= (ID_W + 1)'(NUM_SRAM)) begin
          alloc_err <= 1'b1;
        end else if (own_v[alloc_sram_id] && !(handshake && (free_sram_id == alloc_sram_id))) begin
          alloc_err <= 1'b1;
        end else begin
          own_v[alloc_sram_id] <= 1'b1;
          owner[alloc_sram_id] <= alloc_port;
        end
      end
    end
  end

  // Release qualification: hold counters, re-arm on a low cycle, short-request errors
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      armed     <= '1;
      pending   <= '0;
      short_err <= '0;
      for (int p = 0; p < NUM_PORTS; p++) hold_cnt[p] <= '0;
    end else begin
      short_err <= '0;
      if (state == DONE) pending[gport] <= 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (rel_req[p]) begin
          if (hold_cnt[p] != HOLD_MAX) hold_cnt[p] <= hold_cnt[p] + 1'b1;
          if (armed[p] && (hold_cnt[p] == HOLD_LAST)) begin
            pending[p] <= 1'b1;
            armed[p]   <= 1'b0;
          end
        end else begin
          hold_cnt[p] <= '0;
          armed[p]    <= 1'b1;
          if ((hold_cnt[p] != '0) && (hold_cnt[p] != HOLD_MAX)) short_err[p] <= 1'b1;
        end
      end
    end
  end

  // Service FSM: grant a port, walk its SRAMs in index order, hand each back one at a time
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state        <= IDLE;
      gport        <= '0;
      last_grant   <= PORT_W'(NUM_PORTS - 1);
      ptr          <= '0;
      free_valid   <= 1'b0;
      free_sram_id <= '0;
      rel_done     <= '0;
    end else begin
      rel_done <= '0;
      case (state)
        IDLE: begin
          if (grant_found) begin
            gport      <= grant_sel;
            last_grant <= grant_sel;
            ptr        <= '0;
            state      <= SCAN;
          end
        end
        SCAN: begin
          if (cand_found) begin
            free_sram_id <= cand_sel;
            free_valid   <= 1'b1;
            state        <= ISSUE;
          end else begin
            state <= DONE;
          end
        end
        ISSUE: begin
          if (free_ready) begin
            free_valid <= 1'b0;
            if (free_sram_id == LAST_ID) begin
              state <= DONE;
            end else begin
              ptr   <= free_sram_id + 1'b1;
              state <= SCAN;
            end
          end
        end
        DONE: begin
          rel_done[gport] <= 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_release_ctrl.sv
// tb/tb_sram_release_ctrl.sv - randomized and directed bench with a behavioural model of the release controller
module tb_sram_release_ctrl;

  localparam int NP = 16;
  localparam int NS = 32;
  localparam int MH = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          alloc_valid = 1'b0;
  logic [3:0]    alloc_port = '0;
  logic [4:0]    alloc_sram_id = '0;
  logic [NP-1:0] rel_req = '0;
  logic          free_ready = 1'b1;
  logic          free_valid;
  logic [4:0]    free_sram_id;
  logic [NP-1:0] rel_done;
  logic [NP-1:0] short_err;
  logic          alloc_err;
  logic [NS-1:0] owned_vec;
  logic          busy;

  sram_release_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_port(alloc_port), .alloc_sram_id(alloc_sram_id),
    .rel_req(rel_req), .free_ready(free_ready),
    .free_valid(free_valid), .free_sram_id(free_sram_id),
    .rel_done(rel_done), .short_err(short_err), .alloc_err(alloc_err),
    .owned_vec(owned_vec), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  // Model state: what the spec says the block holds, with the service pass as a mode
  bit  m_own [NS];
  int  m_owner [NS];
  int  m_hold [NP];
  bit  m_armed [NP];
  bit  m_pending [NP];
  int  m_last;
  int  m_port;
  int  m_ptr;
  int  m_mode;   // 0 waiting for a request, 1 looking, 2 offering, 3 finishing
  bit  m_fv;
  int  m_fid;
  logic [NP-1:0] m_rel_done;
  logic [NP-1:0] m_short;
  bit  m_aerr;

  int  hs_log[$];
  int  hs_cyc[$];
  int  grant_log[$];
  int  done_cnt [NP];
  int  short_cnt [NP];
  int  burst_left [NP];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin m_own[i] = 0; m_owner[i] = 0; end
    for (int p = 0; p < NP; p++) begin m_hold[p] = 0; m_armed[p] = 1; m_pending[p] = 0; end
    m_last = NP - 1; m_port = 0; m_ptr = 0; m_mode = 0;
    m_fv = 0; m_fid = 0; m_rel_done = '0; m_short = '0; m_aerr = 0;
  endtask

  function automatic int first_pending();
    for (int k = 1; k <= NP; k++)
      if (m_pending[(m_last + k) % NP]) return (m_last + k) % NP;
    return -1;
  endfunction

  // Advance the model across the next clock edge using the inputs now applied
  task automatic step_model();
    int pick;
    int cid;
    bit hs;
    if (rst_n) begin model_reset(); return; end
    m_rel_done = '0; m_short = '0; m_aerr = 0;
    hs = (m_mode == 2) && free_ready;
    case (m_mode)
      0: begin
        pick = first_pending();
        if (pick >= 0) begin
          m_port = pick; m_last = pick; m_ptr = 0; m_mode = 1;
          grant_log.push_back(pick);
        end
      end
      1: begin
        cid = -1;
        for (int i = NS - 1; i >= m_ptr; i--)
          if (m_own[i] && m_owner[i] == m_port) cid = i;
        if (cid >= 0) begin m_fid = cid; m_fv = 1; m_mode = 2; end
        else m_mode = 3;
      end
      2: begin
        if (free_ready) begin
          m_fv = 0;
          hs_log.push_back(m_fid);
          hs_cyc.push_back(cyc);
          if (m_fid == NS - 1) m_mode = 3;
          else begin m_ptr = m_fid + 1; m_mode = 1; end
        end
      end
      default: begin
        m_rel_done[m_port] = 1'b1;
        done_cnt[m_port]++;
        m_pending[m_port] = 0;
        m_mode = 0;
      end
    endcase
    if (hs) m_own[m_fid] = 0;
    if (alloc_valid) begin
      if (m_own[alloc_sram_id]) m_aerr = 1;
      else begin m_own[alloc_sram_id] = 1; m_owner[alloc_sram_id] = alloc_port; end
    end
    for (int p = 0; p < NP; p++) begin
      if (rel_req[p]) begin
        if (m_hold[p] == MH - 1 && m_armed[p]) begin m_pending[p] = 1; m_armed[p] = 0; end
        if (m_hold[p] < MH) m_hold[p]++;
      end else begin
        if (m_hold[p] >= 1 && m_hold[p] <= MH - 1) begin m_short[p] = 1'b1; short_cnt[p]++; end
        m_hold[p] = 0;
        m_armed[p] = 1;
      end
    end
  endtask

  task automatic compare();
    logic [NS-1:0] e_own;
    for (int i = 0; i < NS; i++) e_own[i] = m_own[i];
    chk("free_valid", free_valid, m_fv);
    chk("free_sram_id", free_sram_id, m_fid);
    chk("rel_done", rel_done, m_rel_done);
    chk("short_err", short_err, m_short);
    chk("alloc_err", alloc_err, m_aerr);
    chk("owned_vec", owned_vec, e_own);
    chk("busy", busy, m_mode != 0);
  endtask

  task automatic cycle();
    step_model();
    @(negedge clk);
    cyc++;
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic alloc_one(input int port, input int id);
    alloc_valid = 1'b1; alloc_port = 4'(port); alloc_sram_id = 5'(id);
    cycle();
    alloc_valid = 1'b0;
  endtask

  task automatic hold_req(input logic [NP-1:0] mask, input int n);
    rel_req = rel_req | mask;
    idle(n);
    rel_req = rel_req & ~mask;
  endtask

  task automatic do_reset();
    rst_n = 1'b1; rel_req = '0; alloc_valid = 1'b0; free_ready = 1'b1;
    idle(2);
    rst_n = 1'b0;
  endtask

  initial begin
    int exp_t1 [3];
    int exp_t3h [4];
    int exp_t3g [4];
    int snap;
    exp_t1 = '{3, 7, 31};
    exp_t3h = '{10, 11, 12, 5};
    exp_t3g = '{0, 1, 15, 0};
    for (int p = 0; p < NP; p++) begin done_cnt[p] = 0; short_cnt[p] = 0; burst_left[p] = 0; end
    model_reset();

    do_reset();
    chk("reset_owned", owned_vec, 0);
    chk("reset_free_valid", free_valid, 0);
    chk("reset_busy", busy, 0);
    idle(1);

    // Three SRAMs released in index order, two cycles apart
    alloc_one(2, 3); alloc_one(2, 7); alloc_one(2, 31);
    hs_log.delete(); hs_cyc.delete();
    hold_req(16'h0004, 5);
    idle(10);
    chk("t1_count", hs_log.size(), 3);
    for (int i = 0; i < 3; i++) chk("t1_id", (i < hs_log.size()) ? hs_log[i] : -1, exp_t1[i]);
    chk("t1_gap", (hs_cyc.size() == 3) ? hs_cyc[2] - hs_cyc[1] : -1, 2);
    chk("t1_done", done_cnt[2], 1);
    chk("t1_owned", owned_vec, 0);

    // Request dropped after four cycles
    hs_log.delete();
    hold_req(16'h0020, 4);
    cycle();
    chk("t2_short", short_err, 16'h0020);
    idle(6);
    chk("t2_short_cnt", short_cnt[5], 1);
    chk("t2_no_free", hs_log.size(), 0);
    chk("t2_no_done", done_cnt[5], 0);
    chk("t2_busy", busy, 0);

    // Same-cycle qualification, round-robin order and a re-request by port 0
    do_reset();
    alloc_one(0, 10); alloc_one(1, 11); alloc_one(15, 12);
    hs_log.delete(); grant_log.delete();
    hold_req(16'h8003, 5);
    cycle();
    rel_req[0] = 1'b1;
    alloc_one(0, 5);
    idle(4);
    rel_req[0] = 1'b0;
    idle(30);
    chk("t3_grants", grant_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("t3_grant", (i < grant_log.size()) ? grant_log[i] : -1, exp_t3g[i]);
    for (int i = 0; i < 4; i++) chk("t3_id", (i < hs_log.size()) ? hs_log[i] : -1, exp_t3h[i]);

    // Back-pressure: offer holds steady and ownership stays until the handshake
    do_reset();
    alloc_one(6, 20);
    hs_log.delete();
    free_ready = 1'b0;
    hold_req(16'h0040, 5);
    idle(2);
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("t4_valid", free_valid, 1);
      chk("t4_id", free_sram_id, 20);
      chk("t4_owned", owned_vec[20], 1);
    end
    free_ready = 1'b1;
    idle(5);
    chk("t4_released", owned_vec[20], 0);
    chk("t4_hs", hs_log.size(), 1);

    // Double allocation, and re-allocation on the release handshake
    do_reset();
    alloc_one(3, 4);
    alloc_one(7, 4);
    chk("t5_dup_err", alloc_err, 1);
    hs_log.delete();
    free_ready = 1'b0;
    hold_req(16'h0008, 5);
    idle(2);
    chk("t5_offer", free_sram_id, 4);
    free_ready = 1'b1;
    alloc_one(9, 4);
    chk("t5_no_err", alloc_err, 0);
    chk("t5_reowned", owned_vec[4], 1);
    idle(6);
    hold_req(16'h0200, 5);
    idle(8);
    chk("t5_hs_count", hs_log.size(), 2);
    chk("t5_done9", done_cnt[9], 1);
    chk("t5_done7", done_cnt[7], 0);

    // Reset while an offer is outstanding
    do_reset();
    alloc_one(1, 8);
    free_ready = 1'b0;
    hold_req(16'h0002, 5);
    idle(2);
    snap = done_cnt[1];
    rst_n = 1'b1;
    cycle();
    chk("t6_valid", free_valid, 0);
    chk("t6_id", free_sram_id, 0);
    chk("t6_owned", owned_vec, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", rel_done, 0);
    rst_n = 1'b0;
    free_ready = 1'b1;
    idle(8);
    chk("t6_no_done", done_cnt[1], snap);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst_n = (c == 1500);
      alloc_valid = ($urandom_range(0, 3) == 0);
      alloc_port = 4'($urandom_range(0, NP - 1));
      alloc_sram_id = 5'($urandom_range(0, NS - 1));
      free_ready = ($urandom_range(0, 9) < 7);
      for (int p = 0; p < NP; p++) begin
        if (burst_left[p] > 0) begin
          rel_req[p] = 1'b1;
          burst_left[p]--;
        end else begin
          rel_req[p] = 1'b0;
          if ($urandom_range(0, 19) == 0) burst_left[p] = $urandom_range(1, 8);
        end
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sram_release_ctrl.md
# sram_release_ctrl

Release-side controller for the dynamic shared cache: it returns SRAMs to the free pool, the reverse of the per-SRAM bitmap allocators that mark them in use. It records which port owns each SRAM from the allocation stream, and qualifies per-port release requests held high for at least MIN_HOLD cycles. It arbitrates qualified ports round-robin and hands each owned SRAM ID back to the free pool over a valid/ready handshake, one ID at a time.

## Interface
- NUM_PORTS, 16, number of requesting ports
- NUM_SRAM, 32, number of shared SRAM banks
- ID_W, 5, SRAM ID width (log2 NUM_SRAM)
- PORT_W, 4, port index width (log2 NUM_PORTS)
- MIN_HOLD, 5, consecutive high cycles that qualify a release request
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-high
- alloc_valid  in  1  allocation event this cycle
- alloc_port  in  PORT_W  port receiving the SRAM
- alloc_sram_id  in  ID_W  SRAM being allocated
- rel_req  in  NUM_PORTS  level release request, one bit per port
- free_ready  in  1  free pool accepts free_sram_id
- free_valid  out  1  free_sram_id is valid
- free_sram_id  out  ID_W  SRAM being returned
- rel_done  out  NUM_PORTS  one-cycle pulse when a port's release completes
- short_err  out  NUM_PORTS  one-cycle pulse when rel_req drops before qualifying
- alloc_err  out  1  one-cycle pulse when allocation targets an SRAM that is already owned
- owned_vec  out  NUM_SRAM  ownership valid bit per SRAM
- busy  out  1  FSM is not in IDLE

## Operation
- Ownership table: owner[NUM_SRAM] (PORT_W bits) plus own_v[NUM_SRAM]. owned_vec = own_v.
- Allocation:
  - alloc_valid with own_v[id]=0: sets own_v[id]=1 and owner[id]=alloc_port.
  - alloc_valid with own_v[id]=1: table unchanged, alloc_err pulses.
  - alloc_sram_id ≥ NUM_SRAM: ignored, alloc_err pulses.
- Per-port hold counter: increments while rel_req[p]=1 and saturates at MIN_HOLD.
  - Reaching MIN_HOLD sets pending[p] and clears armed[p].
  - rel_req[p] falling with the counter at 1..MIN_HOLD-1 pulses short_err[p]. Counter clears whenever rel_req[p]=0.
  - armed[p] is set again only by a cycle with rel_req[p]=0, so a continuously held request never re-qualifies.
  - A pending request is not cancelled by rel_req dropping.
- FSM states are IDLE, SCAN, ISSUE, DONE.
  - IDLE: when any pending bit is set, grant the first pending port at or after last_grant+1 (wrapping). Latch gport, set last_grant=gport, ptr=0, go to SCAN.
  - SCAN: cand = own_v & (owner==gport) & (index ≥ ptr). A priority encoder picks the lowest index. If one is found, load free_sram_id and go to ISSUE; otherwise go to DONE.
  - ISSUE: free_valid=1 and free_sram_id is held stable until free_ready. On handshake, clear own_v[id]. Then set ptr=id+1 and go to SCAN, or go to DONE if id=NUM_SRAM-1.
  - DONE: pulse rel_done[gport], clear pending[gport], go to IDLE.
- Alloc and release clear hitting the same SRAM in the same cycle: the clear applies first, then the alloc sets own_v=1 with the new owner. alloc_err does not pulse.
- An allocation to the granted port during SCAN/ISSUE at an index ≥ ptr is released in the same pass.
- Reset clears the table, counters, pending, arms all ports, sets last_grant=NUM_PORTS-1, and puts the FSM in IDLE. A handshake in flight is abandoned.

## Timing
- Reset values:
  - free_valid=0, free_sram_id=0, rel_done=0, short_err=0, alloc_err=0, owned_vec=0, busy=0.
- All outputs are registered.
- Qualification latency: rel_req[p] sampled high on edges 1..MIN_HOLD sets pending[p] at edge MIN_HOLD.
- Release sequence:
  - edge +1: grant, IDLE→SCAN.
  - edge +2: SCAN→ISSUE; free_valid is high after this edge.
  - With free_ready=1, each SRAM takes 2 cycles (ISSUE plus SCAN). free_valid is low during SCAN.
- A port with no owned SRAMs gets rel_done 3 cycles after qualification, with free_valid never asserted.
- alloc_err and short_err rise one cycle after the offending sample.
- owned_vec updates one cycle after an alloc or handshake.

## Test plan
- Allocate SRAMs 3, 7, 31 to port 2, then hold rel_req[2] 5 cycles with free_ready=1 -> free_sram_id 3, 7, 31 in order, 2 cycles apart; rel_done[2] pulses once; owned_vec=0.
- rel_req[5] high for 4 cycles -> short_err[5] pulse, no free_valid, pending[5] stays 0.
- Ports 0, 1, 15 qualify on the same cycle, each owning 1 SRAM -> service order 0, 1, 15. A re-request by port 0 during service is served after 15.
- free_ready held low 10 cycles during ISSUE -> free_valid and free_sram_id stay stable; own_v cleared only at handshake.
- Allocate SRAM 4 twice -> second alloc_err pulse, owner unchanged. Alloc to 4 on the same cycle as its release handshake -> no alloc_err, owned_vec[4]=1 with the new owner.
- Assert rst_n mid-ISSUE -> all outputs at reset values next cycle, owned_vec=0, no rel_done.
